// File: rtl/regfile.sv
// Architectural integer register file: x1..x31 storage, x0 hardwired to zero,
// two combinational read ports with write bypass and a pending-write scoreboard.
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic        re1_i,
    input  logic [4:0]  raddr1_i,
    output logic [31:0] rdata1_o,
    output logic        busy1_o,
    input  logic        re2_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata2_o,
    output logic        busy2_o,
    input  logic        claim_i,
    input  logic [4:0]  claim_addr_i,
    input  logic        flush_i
);

    logic [31:0] regs [1:31];
    logic [31:1] sb;

    // NOTE: the register array is reset explicitly because reads must return 0
    // after reset; this costs a reset net on every storage flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    // Flush discards everything; a claim outranks a same-cycle write because
    // the claiming instruction is the newer producer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (flush_i) begin
                    sb[i] <= 1'b0;
                end else if (claim_i && (claim_addr_i == 5'(i))) begin
                    sb[i] <= 1'b1;
                end else if (we_i && (waddr_i == 5'(i))) begin
                    sb[i] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [31:0] read_data(input logic re, input logic [4:0] addr);
        if (!rst || !re || (addr == 5'd0)) begin
            return '0;
        end else if (we_i && (waddr_i == addr)) begin
            return wdata_i;
        end else begin
            return regs[addr];
        end
    endfunction

    // A write landing in the same cycle satisfies the hazard it would flag.
    function automatic logic read_busy(input logic re, input logic [4:0] addr);
        if (!rst || !re || (addr == 5'd0)) begin
            return 1'b0;
        end else begin
            return sb[addr] && !(we_i && (waddr_i == addr));
        end
    endfunction

    // NOTE: combinational outputs use always_comb with every output assigned on
    // every path, so no latch can be inferred.
    always_comb begin
        rdata1_o = read_data(re1_i, raddr1_i);
        busy1_o  = read_busy(re1_i, raddr1_i);
        rdata2_o = read_data(re2_i, raddr2_i);
        busy2_o  = read_busy(re2_i, raddr2_i);
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: expected port values are queued when the
// stimulus is applied and compared once the combinational outputs settle.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        re1_i;
    logic [4:0]  raddr1_i;
    logic [31:0] rdata1_o;
    logic        busy1_o;
    logic        re2_i;
    logic [4:0]  raddr2_i;
    logic [31:0] rdata2_o;
    logic        busy2_o;
    logic        claim_i;
    logic [4:0]  claim_addr_i;
    logic        flush_i;

    regfile dut (
        .clk          (clk),
        .rst          (rst),
        .we_i         (we_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .re1_i        (re1_i),
        .raddr1_i     (raddr1_i),
        .rdata1_o     (rdata1_o),
        .busy1_o      (busy1_o),
        .re2_i        (re2_i),
        .raddr2_i     (raddr2_i),
        .rdata2_o     (rdata2_o),
        .busy2_o      (busy2_o),
        .claim_i      (claim_i),
        .claim_addr_i (claim_addr_i),
        .flush_i      (flush_i)
    );

    typedef struct {
        string       tag;
        logic [31:0] d1;
        logic        b1;
        logic [31:0] d2;
        logic        b2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Queue the expected outputs, let the inputs settle, then compare.
    task automatic expect_now(input string tag, input logic [31:0] d1, input logic b1,
                              input logic [31:0] d2, input logic b2);
        exp_t e;
        e.tag = tag; e.d1 = d1; e.b1 = b1; e.d2 = d2; e.b2 = b2;
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        check({e.tag, ".d1"}, rdata1_o, e.d1);
        check({e.tag, ".b1"}, 32'(busy1_o), 32'(e.b1));
        check({e.tag, ".d2"}, rdata2_o, e.d2);
        check({e.tag, ".b2"}, 32'(busy2_o), 32'(e.b2));
    endtask

    // Advance to the falling edge and return write/claim/flush to idle.
    task automatic next_cycle();
        @(negedge clk);
        we_i    = 1'b0;
        claim_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic set_reads(input logic r1, input logic [4:0] a1,
                             input logic r2, input logic [4:0] a2);
        re1_i = r1; raddr1_i = a1; re2_i = r2; raddr2_i = a2;
    endtask

    task automatic set_write(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
    endtask

    task automatic set_claim(input logic [4:0] a);
        claim_i = 1'b1; claim_addr_i = a;
    endtask

    initial begin
        rst = 1'b0;
        we_i = 1'b0; waddr_i = '0; wdata_i = '0;
        claim_i = 1'b0; claim_addr_i = '0; flush_i = 1'b0;
        set_reads(1'b1, 5'd5, 1'b1, 5'd31);
        expect_now("reset_hold", 32'h0, 1'b0, 32'h0, 1'b0);

        // Release reset with a write in the deassertion cycle.
        next_cycle();
        rst = 1'b1;
        set_write(5'd10, 32'h0000_0010);
        set_reads(1'b1, 5'd5, 1'b0, 5'd0);
        expect_now("post_reset_x5", 32'h0, 1'b0, 32'h0, 1'b0);

        next_cycle();
        set_reads(1'b1, 5'd10, 1'b0, 5'd0);
        expect_now("deassert_write", 32'h0000_0010, 1'b0, 32'h0, 1'b0);

        // Plain write then stored read on both ports.
        next_cycle();
        set_write(5'd3, 32'hDEAD_BEEF);
        set_reads(1'b0, 5'd3, 1'b0, 5'd3);
        expect_now("write_x3", 32'h0, 1'b0, 32'h0, 1'b0);

        next_cycle();
        set_reads(1'b1, 5'd3, 1'b1, 5'd3);
        expect_now("read_x3", 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // x0 ignores writes, including through the bypass.
        next_cycle();
        set_write(5'd0, 32'h0000_1234);
        set_reads(1'b1, 5'd0, 1'b1, 5'd3);
        expect_now("write_x0", 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);

        next_cycle();
        expect_now("read_x0", 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Same-cycle bypass, gated by read enable.
        next_cycle();
        set_write(5'd7, 32'hA5A5_A5A5);
        set_reads(1'b1, 5'd7, 1'b0, 5'd7);
        expect_now("bypass_x7", 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0);

        next_cycle();
        set_write(5'd7, 32'h5A5A_5A5A);
        set_reads(1'b0, 5'd7, 1'b1, 5'd3);
        expect_now("bypass_re0", 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);

        next_cycle();
        set_reads(1'b1, 5'd7, 1'b0, 5'd0);
        expect_now("stored_x7", 32'h5A5A_5A5A, 1'b0, 32'h0, 1'b0);

        // Claim x9: busy from the next cycle, cleared by the write.
        next_cycle();
        set_claim(5'd9);
        set_reads(1'b0, 5'd0, 1'b1, 5'd9);
        expect_now("claim_x9", 32'h0, 1'b0, 32'h0, 1'b0);

        next_cycle();
        expect_now("busy_x9", 32'h0, 1'b0, 32'h0, 1'b1);

        next_cycle();
        set_write(5'd9, 32'h0000_0099);
        expect_now("write_x9", 32'h0, 1'b0, 32'h0000_0099, 1'b0);

        next_cycle();
        expect_now("after_x9", 32'h0, 1'b0, 32'h0000_0099, 1'b0);

        // Claim and write of x4 together: claim wins.
        next_cycle();
        set_claim(5'd4);
        set_write(5'd4, 32'h0000_0044);
        set_reads(1'b1, 5'd4, 1'b0, 5'd0);
        expect_now("claim_write_x4", 32'h0000_0044, 1'b0, 32'h0, 1'b0);

        next_cycle();
        expect_now("busy_x4", 32'h0000_0044, 1'b1, 32'h0, 1'b0);

        next_cycle();
        set_write(5'd4, 32'h0000_0045);
        expect_now("clear_x4", 32'h0000_0045, 1'b0, 32'h0, 1'b0);

        next_cycle();
        expect_now("idle_x4", 32'h0000_0045, 1'b0, 32'h0, 1'b0);

        // Flush beats a same-cycle claim.
        next_cycle();
        flush_i = 1'b1;
        set_claim(5'd6);
        set_reads(1'b1, 5'd6, 1'b0, 5'd0);
        expect_now("flush_claim_x6", 32'h0, 1'b0, 32'h0, 1'b0);

        next_cycle();
        expect_now("x6_not_busy", 32'h0, 1'b0, 32'h0, 1'b0);

        // Flush drops an older claim but does not block a write.
        next_cycle();
        set_claim(5'd8);
        set_reads(1'b0, 5'd0, 1'b1, 5'd8);
        expect_now("claim_x8", 32'h0, 1'b0, 32'h0, 1'b0);

        next_cycle();
        expect_now("busy_x8", 32'h0, 1'b0, 32'h0, 1'b1);

        next_cycle();
        flush_i = 1'b1;
        set_write(5'd11, 32'h0000_0088);
        expect_now("flush_x8", 32'h0, 1'b0, 32'h0, 1'b1);

        next_cycle();
        set_reads(1'b1, 5'd11, 1'b1, 5'd8);
        expect_now("after_flush", 32'h0000_0088, 1'b0, 32'h0, 1'b0);

        // A claim of x0 must never produce a busy.
        next_cycle();
        set_claim(5'd0);
        set_reads(1'b1, 5'd0, 1'b1, 5'd0);
        expect_now("claim_x0", 32'h0, 1'b0, 32'h0, 1'b0);

        next_cycle();
        expect_now("x0_not_busy", 32'h0, 1'b0, 32'h0, 1'b0);

        // Asynchronous reset clears a pending claim and stored data mid-cycle.
        next_cycle();
        set_write(5'd2, 32'h0000_0055);
        set_reads(1'b0, 5'd0, 1'b0, 5'd0);
        expect_now("write_x2", 32'h0, 1'b0, 32'h0, 1'b0);

        next_cycle();
        set_claim(5'd2);
        expect_now("claim_x2", 32'h0, 1'b0, 32'h0, 1'b0);

        next_cycle();
        set_reads(1'b1, 5'd2, 1'b1, 5'd2);
        expect_now("busy_x2", 32'h0000_0055, 1'b1, 32'h0000_0055, 1'b1);
        #1;
        rst = 1'b0;
        expect_now("async_reset", 32'h0, 1'b0, 32'h0, 1'b0);

        next_cycle();
        rst = 1'b1;
        expect_now("after_reset_x2", 32'h0, 1'b0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=%0d exp=%0d", checks, 0);
        $fatal(1, "bench timeout");
    end

endmodule
